// File: rtl/wb_arbiter_pkg.sv
// Shared widths, source indices and payload type for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned NSRC     = 3;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ROBID_W  = 8;
    localparam int unsigned RD_W     = 6;
    localparam int unsigned ECAUSE_W = 5;
    localparam int unsigned PTR_W    = 2;

    localparam logic [PTR_W-1:0] SRC_SCALU = 2'd0;
    localparam logic [PTR_W-1:0] SRC_LSQ   = 2'd1;
    localparam logic [PTR_W-1:0] SRC_MDU   = 2'd2;

    // One writeback result as carried from a source to the broadcast bus.
    typedef struct packed {
        logic                error;
        logic [ECAUSE_W-1:0] ecause;
        logic [ROBID_W-1:0]  robid;
        logic [RD_W-1:0]     rd;
        logic [DATA_W-1:0]   result;
    } wb_payload_t;

    // Round-robin pointer value following a grant to source g.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
        return (g == SRC_MDU) ? SRC_SCALU : PTR_W'(g + PTR_W'(1));
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-requester round-robin arbiter: one-hot grant to the first request
// at or after ptr, wrapping mdu -> scalu. Pointer state lives in the parent.
module rr_arb3
    import wb_arbiter_pkg::*;
(
    input  logic [NSRC-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NSRC-1:0]  grant
);

    // Priority search rotated by ptr; an out-of-range ptr behaves as scalu.
    always_comb begin
        grant = '0;
        case (ptr)
            SRC_LSQ: begin
                if (req[SRC_LSQ])        grant[SRC_LSQ]   = 1'b1;
                else if (req[SRC_MDU])   grant[SRC_MDU]   = 1'b1;
                else if (req[SRC_SCALU]) grant[SRC_SCALU] = 1'b1;
            end
            SRC_MDU: begin
                if (req[SRC_MDU])        grant[SRC_MDU]   = 1'b1;
                else if (req[SRC_SCALU]) grant[SRC_SCALU] = 1'b1;
                else if (req[SRC_LSQ])   grant[SRC_LSQ]   = 1'b1;
            end
            default: begin
                if (req[SRC_SCALU])      grant[SRC_SCALU] = 1'b1;
                else if (req[SRC_LSQ])   grant[SRC_LSQ]   = 1'b1;
                else if (req[SRC_MDU])   grant[SRC_MDU]   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of scalu/lsq/mdu per cycle round-robin,
// stalls the losers and drives a registered result broadcast one cycle later.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                scalu_valid,
    input  logic                scalu_error,
    input  logic [ECAUSE_W-1:0] scalu_ecause,
    input  logic [ROBID_W-1:0]  scalu_robid,
    input  logic [RD_W-1:0]     scalu_rd,
    input  logic [DATA_W-1:0]   scalu_result,
    output logic                wb_scalu_stall,

    input  logic                lsq_valid,
    input  logic                lsq_error,
    input  logic [ECAUSE_W-1:0] lsq_ecause,
    input  logic [ROBID_W-1:0]  lsq_robid,
    input  logic [RD_W-1:0]     lsq_rd,
    input  logic [DATA_W-1:0]   lsq_result,
    output logic                wb_lsq_stall,

    input  logic                mdu_valid,
    input  logic                mdu_error,
    input  logic [ECAUSE_W-1:0] mdu_ecause,
    input  logic [ROBID_W-1:0]  mdu_robid,
    input  logic [RD_W-1:0]     mdu_rd,
    input  logic [DATA_W-1:0]   mdu_result,
    output logic                wb_mdu_stall,

    input  logic                rob_flush,

    output logic                wb_valid,
    output logic                wb_error,
    output logic [ECAUSE_W-1:0] wb_ecause,
    output logic [ROBID_W-1:0]  wb_robid,
    output logic [RD_W-1:0]     wb_rd,
    output logic [DATA_W-1:0]   wb_result
);

    logic [PTR_W-1:0] rr_ptr;
    logic [NSRC-1:0]  req;
    logic [NSRC-1:0]  grant;
    logic             any_grant;
    logic [PTR_W-1:0] grant_idx;
    wb_payload_t      src_pl [NSRC];
    wb_payload_t      sel_pl;
    wb_payload_t      wb_pl;

    assign req = {mdu_valid, lsq_valid, scalu_valid};

    assign src_pl[SRC_SCALU] = '{error: scalu_error, ecause: scalu_ecause,
                                 robid: scalu_robid, rd: scalu_rd, result: scalu_result};
    assign src_pl[SRC_LSQ]   = '{error: lsq_error, ecause: lsq_ecause,
                                 robid: lsq_robid, rd: lsq_rd, result: lsq_result};
    assign src_pl[SRC_MDU]   = '{error: mdu_error, ecause: mdu_ecause,
                                 robid: mdu_robid, rd: mdu_rd, result: mdu_result};

    rr_arb3 u_rr_arb3 (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Losers stall; an idle source never sees a stall.
    assign wb_scalu_stall = req[SRC_SCALU] & ~grant[SRC_SCALU];
    assign wb_lsq_stall   = req[SRC_LSQ]   & ~grant[SRC_LSQ];
    assign wb_mdu_stall   = req[SRC_MDU]   & ~grant[SRC_MDU];

    assign any_grant = |grant;

    // Encode the one-hot grant for the pointer update.
    always_comb begin
        grant_idx = SRC_SCALU;
        if (grant[SRC_LSQ]) grant_idx = SRC_LSQ;
        if (grant[SRC_MDU]) grant_idx = SRC_MDU;
    end

    // One-hot AND-OR mux of the granted source's payload.
    always_comb begin
        sel_pl = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (grant[i]) sel_pl = sel_pl | src_pl[i];
        end
    end

    // Round-robin pointer: advance past the winner; hold on idle or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= SRC_SCALU;
        end else if (!rob_flush && any_grant) begin
            rr_ptr <= next_ptr(grant_idx);
        end
    end

    // Broadcast register: payload loads only on a captured grant so it never
    // changes while wb_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_pl    <= '0;
        end else if (rob_flush) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= any_grant;
            if (any_grant) wb_pl <= sel_pl;
        end
    end

    assign wb_error  = wb_pl.error;
    assign wb_ecause = wb_pl.ecause;
    assign wb_robid  = wb_pl.robid;
    assign wb_rd     = wb_pl.rd;
    assign wb_result = wb_pl.result;

endmodule
